ahb_lite_manager: RTL and testbench
===================================

// Module: ahb_lite_manager
// PURPOSE
// - Bus initiator for AHB-Lite: turns a simple valid/ready request stream into pipelined single transfers.
// - Sends the responses back in order.
// - Drives the flat AHB-Lite manager signals that the host subordinate bridge and the peripherals consume.
// - Used as the CPU-side stub in the verilator harness and by the future descriptor DMA.
// PARAMETERS
// - ADDR_W  32  address width for haddr_o and req_addr_i
// - DATA_W  32  data width for hwdata_o, hrdata_i, req_wdata_i and rsp_rdata_o
// PORTS
// - clk_i        in   1       single clock
// - rst_i        in   1       synchronous reset, active-high
// - req_valid_i  in   1       request present
// - req_ready_o  out  1       request accepted on a cycle where req_valid_i && req_ready_o
// - req_write_i  in   1       1 = write, 0 = read
// - req_addr_i   in   ADDR_W  byte address
// - req_size_i   in   3       HSIZE encoding, passed through unchanged
// - req_wdata_i  in   DATA_W  write data, already lane-aligned by the caller
// - rsp_valid_o  out  1       one-cycle response pulse; consumer is always ready
// - rsp_rdata_o  out  DATA_W  read data; 0 for writes
// - rsp_error_o  out  1       subordinate returned ERROR
// - haddr_o      out  ADDR_W  AHB address
// - hwrite_o     out  1       AHB write
// - htrans_o     out  2       AHB transfer type; only IDLE=00 and NONSEQ=10 are driven
// - hsize_o      out  3       AHB size
// - hwdata_o     out  DATA_W  AHB write data
// - hrdata_i     in   DATA_W  AHB read data
// - hready_i     in   1       AHB ready
// - hresp_i      in   1       AHB response; 1 = ERROR
// BEHAVIOUR
// - Two register slots:
//   - AP (address phase): ap_valid, addr, write, size, wdata.
//   - DP (data phase): dp_valid, write, wdata.
// - All AHB outputs come straight from registers.
// - Address-phase outputs:
//   - htrans_o = (ap_valid && !suppress) ? NONSEQ : IDLE.
//   - haddr_o, hwrite_o and hsize_o come from AP.
//   - hwdata_o = DP wdata.
// - Reset values: htrans_o=IDLE; haddr_o, hwdata_o, hsize_o, hwrite_o = 0; rsp_* = 0; both slots and suppress = 0.
// - Ready rule (combinational): req_ready_o = !rst_i && !suppress && !err1 && (!ap_valid || hready_i).
//   - err1 = dp_valid && hresp_i && !hready_i.
// - Request accepted at edge N: AP loads, giving address phase in cycle N+1.
// - Address completes on a cycle with hready_i=1, htrans_o=NONSEQ: AP moves to DP (data phase next cycle).
//   - If a request is accepted on that same edge, AP reloads with it.
//   - Otherwise ap_valid clears.
// - Data completes on a cycle with dp_valid && hready_i=1:
//   - Next cycle: rsp_valid_o=1, rsp_error_o=hresp_i, rsp_rdata_o = read ? hrdata_i : 0.
//   - If no new address completes on that edge, dp_valid clears.
// - Latency with zero wait states: accept at edge N, NONSEQ in N+1, data in N+2, rsp_valid_o in N+3.
// - Throughput: one transfer per cycle.
// - hready_i=0:
//   - AP and DP hold; haddr_o, hwrite_o, hsize_o and hwdata_o stay stable.
//   - No response is issued.
//   - htrans_o is never changed while a NONSEQ is waiting (AHB-Lite rule).
// - Two-cycle ERROR:
//   - Cycle 1 (err1): set suppress.
//   - While suppress=1: htrans_o=IDLE, and AP is retained, not dropped.
//   - Cycle 2 (hresp_i=1, hready_i=1): the erroring transfer completes with rsp_error_o=1; DP clears.
//   - suppress then clears, and the retained AP re-issues as NONSEQ in the following cycle.
// - Ordering: responses are returned strictly in request order, and each accepted request gets exactly one response.
// - ERROR on a transfer whose AP slot is empty: completes with rsp_error_o=1 and nothing to suppress; suppress still clears after cycle 2.
// - hresp_i=1 with dp_valid=0: ignored.
// - Reset mid-transfer: all slots are flushed and no responses are issued for abandoned transfers.
//   - htrans_o=IDLE from the cycle after rst_i is sampled.
// - No alignment check, no bursts, no byte-lane replication: the caller is responsible for all three.
// TESTING
// - Single write, hready_i=1: addr 0x100, wdata 0xDEADBEEF accepted at edge N.
//   -> N+1: NONSEQ, haddr 0x100, hwrite 1.
//   -> N+2: hwdata 0xDEADBEEF.
//   -> N+3: rsp_valid 1, rsp_error 0.
// - Back-to-back reads 0x0 and 0x4; subordinate returns 0x11, 0x22.
//   -> NONSEQ on two consecutive cycles.
//   -> rsp_rdata 0x11 then 0x22 on consecutive cycles.
// - Write 0x8 (data 0xA5) then read 0xC; hready_i=0 for 3 cycles during the write data phase.
//   -> haddr 0xC, NONSEQ and hwdata 0xA5 held 3 cycles.
//   -> req_ready_o=0 throughout.
//   -> responses still in order.
// - Read 0x10 then write 0x14; two-cycle ERROR on the read.
//   -> rsp_error 1 for the read.
//   -> htrans IDLE for 1 cycle, then NONSEQ 0x14.
//   -> write completes with rsp_error 0.
// - rst_i asserted while hready_i=0 and both slots are full.
//   -> next cycle: htrans IDLE, rsp_valid 0, req_ready_o 1.
//   -> no stale responses afterwards.
// - Random valid/ready/hready_i with a reference queue model.
//   -> response count equals accept count, and every rdata/error matches the model.

Source files
------------

// File: rtl/ahb_lite_manager.sv
// AHB-Lite manager: converts a valid/ready request stream into pipelined
// single NONSEQ transfers and returns one in-order response per request.
// Two register slots form the pipeline: AP holds the transfer currently in
// its address phase, DP holds the transfer currently in its data phase.
module ahb_lite_manager #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [2:0]        req_size_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_error_o,
  output logic [ADDR_W-1:0] haddr_o,
  output logic              hwrite_o,
  output logic [1:0]        htrans_o,
  output logic [2:0]        hsize_o,
  output logic [DATA_W-1:0] hwdata_o,
  input  logic [DATA_W-1:0] hrdata_i,
  input  logic              hready_i,
  input  logic              hresp_i
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Address-phase slot
  logic              ap_valid;
  logic [ADDR_W-1:0] ap_addr;
  logic              ap_write;
  logic [2:0]        ap_size;
  logic [DATA_W-1:0] ap_wdata;

  // Data-phase slot
  logic              dp_valid;
  logic              dp_write;
  logic [DATA_W-1:0] dp_wdata;

  // Set during the first ERROR cycle; forces IDLE and holds AP until the
  // erroring transfer finishes its second ERROR cycle.
  logic              suppress;

  // Registered response
  logic              rsp_valid_q;
  logic              rsp_error_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic err1;
  logic accept;
  logic addr_done;
  logic data_done;

  // Handshake: a request transfers on any cycle where req_valid_i && req_ready_o.
  // The caller must hold req_* stable while req_valid_i is high and
  // req_ready_o is low. The response side has no back-pressure: rsp_valid_o
  // is a single-cycle pulse the consumer always takes.
  always_comb begin
    err1        = dp_valid && hresp_i && !hready_i;
    req_ready_o = !rst_i && !suppress && !err1 && (!ap_valid || hready_i);
    accept      = req_valid_i && req_ready_o;
    addr_done   = ap_valid && !suppress && hready_i;
    data_done   = dp_valid && hready_i;
  end

  // Address-phase slot: load on accept, otherwise drain when the address completes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ap_valid <= 1'b0;
      ap_addr  <= '0;
      ap_write <= 1'b0;
      ap_size  <= '0;
      ap_wdata <= '0;
    end else if (accept) begin
      ap_valid <= 1'b1;
      ap_addr  <= req_addr_i;
      ap_write <= req_write_i;
      ap_size  <= req_size_i;
      ap_wdata <= req_wdata_i;
    end else if (addr_done) begin
      ap_valid <= 1'b0;
    end
  end

  // Data-phase slot: take over AP when its address completes, else drain on data completion
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_wdata <= '0;
    end else if (addr_done) begin
      dp_valid <= 1'b1;
      dp_write <= ap_write;
      dp_wdata <= ap_wdata;
    end else if (data_done) begin
      dp_valid <= 1'b0;
    end
  end

  // Suppress flag: raised by the first ERROR cycle, dropped once the transfer completes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      suppress <= 1'b0;
    end else if (err1) begin
      suppress <= 1'b1;
    end else if (data_done) begin
      suppress <= 1'b0;
    end
  end

  // Response register: one pulse per completed data phase, read data only for reads
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= data_done;
      rsp_error_q <= data_done && hresp_i;
      rsp_rdata_q <= (data_done && !dp_write) ? hrdata_i : '0;
    end
  end

  // Bus outputs are taken directly from the slot registers
  always_comb begin
    htrans_o    = (ap_valid && !suppress) ? HTRANS_NONSEQ : HTRANS_IDLE;
    haddr_o     = ap_addr;
    hwrite_o    = ap_write;
    hsize_o     = ap_size;
    hwdata_o    = dp_wdata;
    rsp_valid_o = rsp_valid_q;
    rsp_error_o = rsp_error_q;
    rsp_rdata_o = rsp_rdata_q;
  end

endmodule

// File: tb/tb_ahb_lite_manager.sv
// Testbench for ahb_lite_manager: a behavioural AHB-Lite subordinate plus
// queues of expected responses, address phases and write data.
module tb_ahb_lite_manager;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_i;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_write_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [2:0]        req_size_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_error_o;
  logic [ADDR_W-1:0] haddr_o;
  logic              hwrite_o;
  logic [1:0]        htrans_o;
  logic [2:0]        hsize_o;
  logic [DATA_W-1:0] hwdata_o;
  logic [DATA_W-1:0] hrdata_i;
  logic              hready_i;
  logic              hresp_i;

  always #5 clk = ~clk;

  ahb_lite_manager #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_size_i  (req_size_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_error_o (rsp_error_o),
    .haddr_o     (haddr_o),
    .hwrite_o    (hwrite_o),
    .htrans_o    (htrans_o),
    .hsize_o     (hsize_o),
    .hwdata_o    (hwdata_o),
    .hrdata_i    (hrdata_i),
    .hready_i    (hready_i),
    .hresp_i     (hresp_i)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  int accepts  = 0;
  int rsps     = 0;

  logic [DATA_W:0]   exp_q[$];   // {error, rdata} in request order
  logic [DATA_W-1:0] wd_q[$];    // write data in request order
  logic [ADDR_W+3:0] aq[$];      // {write, size, addr} in request order

  // Subordinate model state
  bit                sub_dp = 0;
  logic [ADDR_W-1:0] sub_addr = '0;
  bit                sub_write = 0;
  bit                sub_err = 0;
  bit                sub_stage = 0;
  int                sub_wait = 0;
  int                wait_once = 0;
  bit                rand_wait_en = 0;
  bit                rand_err_en = 0;
  bit                idle_hresp = 0;
  logic [ADDR_W-1:0] err_addr = '1;

  // Values sampled in the current cycle
  logic [1:0]        obs_htrans;
  logic [ADDR_W-1:0] obs_haddr;
  logic              obs_hwrite;
  logic [2:0]        obs_hsize;
  logic [DATA_W-1:0] obs_hwdata;
  logic              obs_rsp_valid;
  logic              obs_rsp_error;
  logic [DATA_W-1:0] obs_rsp_rdata;
  logic              obs_ready;
  bit                obs_accept = 0;

  function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
    return DATA_W'(((a >> 2) + 1) * 32'h11);
  endfunction

  function automatic bit sub_err_for(input logic [ADDR_W-1:0] a);
    return (a == err_addr) || (rand_err_en && (a[4:2] == 3'b111));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_req(input bit v, input bit w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
    req_valid_i = v;
    req_write_i = w;
    req_addr_i  = a;
    req_size_i  = 3'b010;
    req_wdata_i = d;
  endtask

  // One bus cycle, entered just after a falling edge: drive the subordinate,
  // sample, run the scoreboard, cross the rising edge, advance the model.
  task automatic cycle();
    logic [DATA_W:0]   e;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W+3:0] ea;
    bit a_done;
    bit was_rst;
    if (sub_dp) begin
      hrdata_i = sub_write ? 32'hBADBAD00 : rd_val(sub_addr);
      if (sub_wait > 0) begin
        hready_i = 1'b0; hresp_i = 1'b0;
      end else if (sub_err && !sub_stage) begin
        hready_i = 1'b0; hresp_i = 1'b1;
      end else begin
        hready_i = 1'b1; hresp_i = sub_err;
      end
    end else begin
      hready_i = 1'b1;
      hresp_i  = idle_hresp;
      hrdata_i = 32'hBADBAD00;
    end
    #1;
    obs_htrans    = htrans_o;
    obs_haddr     = haddr_o;
    obs_hwrite    = hwrite_o;
    obs_hsize     = hsize_o;
    obs_hwdata    = hwdata_o;
    obs_rsp_valid = rsp_valid_o;
    obs_rsp_error = rsp_error_o;
    obs_rsp_rdata = rsp_rdata_o;
    obs_ready     = req_ready_o;
    obs_accept    = req_valid_i && req_ready_o;

    if (obs_accept) begin
      accepts++;
      exp_q.push_back({sub_err_for(req_addr_i),
                       req_write_i ? {DATA_W{1'b0}} : rd_val(req_addr_i)});
      if (req_write_i) wd_q.push_back(req_wdata_i);
      aq.push_back({req_write_i, req_size_i, req_addr_i});
    end

    if (obs_rsp_valid) begin
      rsps++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_rsp unexpected response err=%0b rdata=%h", obs_rsp_error, obs_rsp_rdata);
      end else begin
        e = exp_q.pop_front();
        if ({obs_rsp_error, obs_rsp_rdata} !== e) begin
          failures++;
          $display("FAIL sb_rsp actual err=%0b rdata=%h expected err=%0b rdata=%h",
                   obs_rsp_error, obs_rsp_rdata, e[DATA_W], e[DATA_W-1:0]);
        end
      end
    end

    if (sub_dp && hready_i && sub_write) begin
      checks++;
      if (wd_q.size() == 0) begin
        failures++;
        $display("FAIL sb_hwdata write data phase with no pending write, hwdata=%h", obs_hwdata);
      end else begin
        wd = wd_q.pop_front();
        if (obs_hwdata !== wd) begin
          failures++;
          $display("FAIL sb_hwdata actual=%h expected=%h", obs_hwdata, wd);
        end
      end
    end

    a_done = (obs_htrans == 2'b10) && hready_i;
    if (a_done) begin
      checks++;
      if (aq.size() == 0) begin
        failures++;
        $display("FAIL sb_addr address phase with no pending request, haddr=%h", obs_haddr);
      end else begin
        ea = aq.pop_front();
        if ({obs_hwrite, obs_hsize, obs_haddr} !== ea) begin
          failures++;
          $display("FAIL sb_addr actual w=%0b sz=%0d a=%h expected w=%0b sz=%0d a=%h",
                   obs_hwrite, obs_hsize, obs_haddr, ea[ADDR_W+3], ea[ADDR_W+2:ADDR_W],
                   ea[ADDR_W-1:0]);
        end
      end
    end

    was_rst = rst_i;
    @(posedge clk);
    if (sub_dp && hready_i) begin
      sub_dp = 0;
    end else if (sub_dp) begin
      if (sub_wait > 0) sub_wait--;
      else if (sub_err) sub_stage = 1;
    end
    if (a_done) begin
      sub_dp    = 1;
      sub_addr  = obs_haddr;
      sub_write = obs_hwrite;
      sub_err   = sub_err_for(obs_haddr);
      sub_stage = 0;
      sub_wait  = sub_err ? 0 : (rand_wait_en ? int'($urandom_range(0, 2)) : wait_once);
      wait_once = 0;
    end
    if (was_rst) begin
      sub_dp = 0;
      exp_q.delete();
      wd_q.delete();
      aq.delete();
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_i = 1'b1;
    drive_req(0, 0, '0, '0);
    cycle();
    checks++;
    if (obs_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_low actual=%0b expected=0", obs_ready); end
    cycle();
    rst_i = 1'b0;
    cycle();
    checks++;
    if (obs_htrans !== 2'b00) begin failures++; $display("FAIL rst_htrans actual=%0h expected=0", obs_htrans); end
    checks++;
    if ({obs_haddr, obs_hwrite, obs_hsize, obs_hwdata} !== '0) begin
      failures++; $display("FAIL rst_bus actual a=%h w=%0b sz=%0d d=%h expected all 0",
                           obs_haddr, obs_hwrite, obs_hsize, obs_hwdata);
    end
    checks++;
    if ({obs_rsp_valid, obs_rsp_error, obs_rsp_rdata} !== '0) begin
      failures++; $display("FAIL rst_rsp actual v=%0b e=%0b d=%h expected all 0",
                           obs_rsp_valid, obs_rsp_error, obs_rsp_rdata);
    end
    checks++;
    if (obs_ready !== 1'b1) begin failures++; $display("FAIL rst_ready actual=%0b expected=1", obs_ready); end
  endtask

  task automatic test_single_write();
    drive_req(1, 1, 32'h100, 32'hDEADBEEF);
    cycle();
    checks++;
    if (obs_ready !== 1'b1) begin failures++; $display("FAIL wr_accept actual=%0b expected=1", obs_ready); end
    drive_req(0, 0, '0, '0);
    cycle();
    checks++;
    if ({obs_htrans, obs_haddr, obs_hwrite} !== {2'b10, 32'h100, 1'b1}) begin
      failures++; $display("FAIL wr_addr_phase actual t=%0h a=%h w=%0b expected t=2 a=100 w=1",
                           obs_htrans, obs_haddr, obs_hwrite);
    end
    cycle();
    checks++;
    if (obs_hwdata !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_hwdata actual=%h expected=deadbeef", obs_hwdata); end
    cycle();
    checks++;
    if ({obs_rsp_valid, obs_rsp_error} !== 2'b10) begin
      failures++; $display("FAIL wr_rsp actual v=%0b e=%0b expected v=1 e=0", obs_rsp_valid, obs_rsp_error);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    drive_req(1, 0, 32'h0, '0);
    cycle();
    drive_req(1, 0, 32'h4, '0);
    cycle();
    checks++;
    if ({obs_htrans, obs_haddr, obs_ready} !== {2'b10, 32'h0, 1'b1}) begin
      failures++; $display("FAIL b2b_first actual t=%0h a=%h rdy=%0b expected t=2 a=0 rdy=1",
                           obs_htrans, obs_haddr, obs_ready);
    end
    drive_req(0, 0, '0, '0);
    cycle();
    checks++;
    if ({obs_htrans, obs_haddr} !== {2'b10, 32'h4}) begin
      failures++; $display("FAIL b2b_second actual t=%0h a=%h expected t=2 a=4", obs_htrans, obs_haddr);
    end
    cycle();
    checks++;
    if ({obs_rsp_valid, obs_rsp_rdata} !== {1'b1, 32'h11}) begin
      failures++; $display("FAIL b2b_rsp0 actual v=%0b d=%h expected v=1 d=11", obs_rsp_valid, obs_rsp_rdata);
    end
    cycle();
    checks++;
    if ({obs_rsp_valid, obs_rsp_rdata} !== {1'b1, 32'h22}) begin
      failures++; $display("FAIL b2b_rsp1 actual v=%0b d=%h expected v=1 d=22", obs_rsp_valid, obs_rsp_rdata);
    end
    cycle();
    checks++;
    if (obs_rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle actual=%0b expected=0", obs_rsp_valid); end
  endtask

  task automatic test_wait_states();
    wait_once = 3;
    drive_req(1, 1, 32'h8, 32'hA5);
    cycle();
    drive_req(1, 0, 32'hC, '0);
    cycle();
    drive_req(0, 0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({obs_htrans, obs_haddr, obs_hwdata, obs_ready} !== {2'b10, 32'hC, 32'hA5, 1'b0}) begin
        failures++; $display("FAIL wait_hold[%0d] actual t=%0h a=%h d=%h rdy=%0b expected t=2 a=c d=a5 rdy=0",
                             i, obs_htrans, obs_haddr, obs_hwdata, obs_ready);
      end
    end
    cycle();
    checks++;
    if (obs_rsp_valid !== 1'b0) begin failures++; $display("FAIL wait_no_rsp actual=%0b expected=0", obs_rsp_valid); end
    cycle();
    checks++;
    if ({obs_rsp_valid, obs_rsp_error, obs_rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      failures++; $display("FAIL wait_rsp_wr actual v=%0b e=%0b d=%h expected v=1 e=0 d=0",
                           obs_rsp_valid, obs_rsp_error, obs_rsp_rdata);
    end
    cycle();
    checks++;
    if ({obs_rsp_valid, obs_rsp_rdata} !== {1'b1, 32'h44}) begin
      failures++; $display("FAIL wait_rsp_rd actual v=%0b d=%h expected v=1 d=44", obs_rsp_valid, obs_rsp_rdata);
    end
  endtask

  task automatic test_error();
    err_addr = 32'h10;
    drive_req(1, 0, 32'h10, '0);
    cycle();
    drive_req(1, 1, 32'h14, 32'h77);
    cycle();
    drive_req(0, 0, '0, '0);
    cycle();
    checks++;
    if ({obs_htrans, obs_haddr, obs_ready} !== {2'b10, 32'h14, 1'b0}) begin
      failures++; $display("FAIL err_cycle1 actual t=%0h a=%h rdy=%0b expected t=2 a=14 rdy=0",
                           obs_htrans, obs_haddr, obs_ready);
    end
    cycle();
    checks++;
    if ({obs_htrans, obs_ready, obs_rsp_valid} !== {2'b00, 1'b0, 1'b0}) begin
      failures++; $display("FAIL err_cycle2 actual t=%0h rdy=%0b v=%0b expected t=0 rdy=0 v=0",
                           obs_htrans, obs_ready, obs_rsp_valid);
    end
    cycle();
    checks++;
    if ({obs_rsp_valid, obs_rsp_error, obs_rsp_rdata} !== {1'b1, 1'b1, 32'h55}) begin
      failures++; $display("FAIL err_rsp actual v=%0b e=%0b d=%h expected v=1 e=1 d=55",
                           obs_rsp_valid, obs_rsp_error, obs_rsp_rdata);
    end
    checks++;
    if ({obs_htrans, obs_haddr} !== {2'b10, 32'h14}) begin
      failures++; $display("FAIL err_reissue actual t=%0h a=%h expected t=2 a=14", obs_htrans, obs_haddr);
    end
    cycle();
    checks++;
    if (obs_hwdata !== 32'h77) begin failures++; $display("FAIL err_wr_data actual=%h expected=77", obs_hwdata); end
    cycle();
    checks++;
    if ({obs_rsp_valid, obs_rsp_error} !== 2'b10) begin
      failures++; $display("FAIL err_wr_rsp actual v=%0b e=%0b expected v=1 e=0", obs_rsp_valid, obs_rsp_error);
    end
    err_addr = '1;
    cycle();
  endtask

  task automatic test_reset_mid();
    wait_once = 5;
    drive_req(1, 1, 32'h20, 32'h1234);
    cycle();
    drive_req(1, 0, 32'h24, '0);
    cycle();
    drive_req(0, 0, '0, '0);
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    cycle();
    checks++;
    if ({obs_htrans, obs_rsp_valid, obs_ready} !== {2'b00, 1'b0, 1'b1}) begin
      failures++; $display("FAIL rstmid_after actual t=%0h v=%0b rdy=%0b expected t=0 v=0 rdy=1",
                           obs_htrans, obs_rsp_valid, obs_ready);
    end
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if (obs_rsp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_stale[%0d] actual=%0b expected=0", i, obs_rsp_valid); end
    end
  endtask

  task automatic test_random();
    int acc0;
    int rsp0;
    int guard;
    acc0 = accepts;
    rsp0 = rsps;
    rand_wait_en = 1;
    rand_err_en  = 1;
    obs_accept   = 0;
    for (int i = 0; i < 400; i++) begin
      if (!req_valid_i || obs_accept) begin
        req_valid_i = ($urandom_range(0, 9) < 7);
        req_write_i = $urandom_range(0, 1);
        req_addr_i  = ADDR_W'($urandom_range(0, 63)) << 2;
        req_size_i  = 3'($urandom_range(0, 2));
        req_wdata_i = $urandom;
      end
      idle_hresp = $urandom_range(0, 1);
      cycle();
    end
    req_valid_i = 1'b0;
    idle_hresp  = 0;
    guard = 0;
    while ((exp_q.size() != 0) && (guard < 100)) begin
      cycle();
      guard++;
    end
    cycle();
    cycle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL rand_drain pending=%0d expected=0 after %0d cycles", exp_q.size(), guard);
    end
    checks++;
    if ((rsps - rsp0) != (accepts - acc0)) begin
      failures++; $display("FAIL rand_count responses=%0d accepts=%0d", rsps - rsp0, accepts - acc0);
    end
    rand_wait_en = 0;
    rand_err_en  = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_i    = 1'b1;
    hready_i = 1'b1;
    hresp_i  = 1'b0;
    hrdata_i = '0;
    drive_req(0, 0, '0, '0);
    @(negedge clk);
    test_reset();
    test_single_write();
    test_back_to_back();
    test_wait_states();
    test_error();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
